reg_select_encode: RTL and testbench
====================================

Name: reg_select_encode

Overview:
- Register-file select-and-encode unit for the single-core processor's decode stage.
- Extracts a 4-bit register number from the IR fields ra/rb/rc under control-unit strobes Gra/Grb/Grc and decodes it one-hot to 16 lines.
- Gates the one-hot vector with Rin, Rout and BAout to produce per-register write and read enables for R0..R15.
- Also provides the sign-extended C constant from the IR and a registered copy of the last selected register number for debug and trace.

Parameters:
- NREGS, 16, number of general registers; must equal 2**RNUM_W.
- RNUM_W, 4, register-number width.
- IR_W, 32, instruction register width.

Ports:
- clk  input  1  system clock; only the trace register uses it.
- rst_n  input  1  asynchronous active-low reset.
- ir_val  input  32  current instruction register value.
- Gra  input  1  select ra field, ir_val[26:23].
- Grb  input  1  select rb field, ir_val[22:19].
- Grc  input  1  select rc field, ir_val[18:15].
- r_in_enable  input  1  Rin strobe, write to the selected register.
- r_out_enable  input  1  Rout strobe, drive the selected register onto the bus.
- BA_out  input  1  base-address out strobe.
- rnum  output  4  decoded register number.
- r_select_vec  output  16  one-hot decode of rnum.
- r_in  output  16  per-register write enables.
- r_out  output  16  per-register bus-drive enables.
- c_sign_ext  output  32  ir_val[18:0] sign-extended from bit 18.
- multi_sel  output  1  more than one of Gra/Grb/Grc asserted.
- rnum_q  output  4  registered last-used register number.

Behaviour:
- All outputs except rnum_q are purely combinational, with zero cycle latency; they settle within the same delta or cycle as the inputs.
- rnum = (ir_val[26:23] & {4{Gra}}) | (ir_val[22:19] & {4{Grb}}) | (ir_val[18:15] & {4{Grc}}).
  - Multiple strobes OR their fields together; this is legal but flagged by multi_sel = (Gra+Grb+Grc) > 1.
  - No strobe gives rnum = 0.
- r_select_vec[i] = (rnum == i). Exactly one bit is set at all times, including R0 when no strobe is asserted.
- r_in = r_select_vec & {16{r_in_enable}}.
- r_out = r_select_vec & {16{r_out_enable | BA_out}}.
- r_in and r_out are independent: both may be nonzero simultaneously if both strobes are asserted.
- BA_out treatment: to the enables, BA_out behaves identically to Rout. Forcing R0 to read as zero under BAout is the register file's responsibility, not this block's.
- c_sign_ext = {{13{ir_val[18]}}, ir_val[18:0]}.
- rnum_q:
  - On rising clk, if (r_in_enable | r_out_enable | BA_out), rnum_q <= rnum; otherwise it holds.
  - rst_n low asynchronously forces rnum_q = 0, regardless of clk.
  - Release of rst_n takes effect at the next rising edge.
- Reset does not affect the combinational outputs; they track their inputs during reset.
- No X propagation: every output is fully defined for any defined input.

Test Plan:
1. ir_val[26:23]=5, [22:19]=6, [18:15]=7, others 0. Gra=1, r_in_enable=1 -> rnum=5, r_in=0000_0000_0010_0000, r_out=0.
2. Same IR, Grb=1, r_out_enable=1 (Gra=0, Rin=0) -> rnum=6, r_in=0, r_out=0000_0000_0100_0000.
3. Same IR, Grc=1, BA_out=1, other strobes 0 -> rnum=7, r_in=0, r_out=0000_0000_1000_0000; multi_sel=0.
4. No G strobe, r_in_enable=1 and r_out_enable=1 -> rnum=0, r_in=r_out=0x0001. Then Gra=Grb=1 with ra=5, rb=6 -> rnum=7, multi_sel=1.
5. Sign extension:
   - ir_val[18:0]=0x40000 -> c_sign_ext=0xFFFC0000.
   - ir_val[18:0]=0x3FFFF -> c_sign_ext=0x0003FFFF.
6. rnum_q clocking and reset:
   - Assert rst_n=0 mid-cycle -> rnum_q=0 immediately.
   - Release, then clock with Gra=1, Rin=1, ra=5 -> rnum_q=5 after the edge.
   - Clock again with all enables 0 and Grb=1 -> rnum_q stays 5.

Source files
------------

// File: rtl/reg_select_encode_if.sv
// Decode-stage register select bundle: IR and control strobes in, register
// number, one-hot enables, C constant and trace register out.
interface reg_select_encode_if #(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned RNUM_W = 4,
  parameter int unsigned IR_W   = 32
);
  logic [IR_W-1:0]   ir_val;
  logic              Gra;
  logic              Grb;
  logic              Grc;
  logic              r_in_enable;
  logic              r_out_enable;
  logic              BA_out;

  logic [RNUM_W-1:0] rnum;
  logic [NREGS-1:0]  r_select_vec;
  logic [NREGS-1:0]  r_in;
  logic [NREGS-1:0]  r_out;
  logic [IR_W-1:0]   c_sign_ext;
  logic              multi_sel;
  logic [RNUM_W-1:0] rnum_q;

  modport master (
    output ir_val, Gra, Grb, Grc, r_in_enable, r_out_enable, BA_out,
    input  rnum, r_select_vec, r_in, r_out, c_sign_ext, multi_sel, rnum_q
  );

  modport slave (
    input  ir_val, Gra, Grb, Grc, r_in_enable, r_out_enable, BA_out,
    output rnum, r_select_vec, r_in, r_out, c_sign_ext, multi_sel, rnum_q
  );
endinterface

// File: rtl/reg_select_encode.sv
// Register select-and-encode for the decode stage: picks ra/rb/rc, decodes one-hot,
// gates with Rin/Rout/BAout, sign-extends the C constant and traces the last register.
module reg_select_encode #(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned RNUM_W = 4,
  parameter int unsigned IR_W   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_select_encode_if.slave  bus
);

  logic [RNUM_W-1:0] rnum;
  logic [NREGS-1:0]  select_vec;
  logic              trace_en;
  logic [RNUM_W-1:0] rnum_trace_d;
  logic [RNUM_W-1:0] rnum_trace_q;

  // Overlapping strobes OR their fields; multi_sel flags that case for the control unit.
  assign rnum = (bus.ir_val[26:23] & {RNUM_W{bus.Gra}})
              | (bus.ir_val[22:19] & {RNUM_W{bus.Grb}})
              | (bus.ir_val[18:15] & {RNUM_W{bus.Grc}});

  always_comb begin
    select_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      select_vec[i] = (rnum == RNUM_W'(i));
    end
  end

  assign bus.rnum         = rnum;
  assign bus.r_select_vec = select_vec;
  assign bus.r_in         = select_vec & {NREGS{bus.r_in_enable}};
  // BAout drives the bus like Rout; zeroing R0 under BAout is left to the register file.
  assign bus.r_out        = select_vec & {NREGS{bus.r_out_enable | bus.BA_out}};
  assign bus.c_sign_ext   = {{(IR_W - 19){bus.ir_val[18]}}, bus.ir_val[18:0]};
  assign bus.multi_sel    = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);

  assign trace_en     = bus.r_in_enable | bus.r_out_enable | bus.BA_out;
  assign rnum_trace_d = trace_en ? rnum : rnum_trace_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnum_trace_q <= '0;
    end else begin
      rnum_trace_q <= rnum_trace_d;
    end
  end

  assign bus.rnum_q = rnum_trace_q;

  // Opcode bits above the ra field are not needed here.
  logic unused_ir_hi;
  assign unused_ir_hi = ^bus.ir_val[IR_W-1:27];

endmodule

// File: tb/tb_reg_select_encode.sv
// Scoreboard bench for reg_select_encode: a driver pushes model expectations,
// a monitor pops and compares one item per clock.
module tb_reg_select_encode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_select_encode_if bus ();

  reg_select_encode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [3:0]  rnum;
    logic [15:0] sel;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [31:0] cse;
    logic        multi;
    logic [3:0]  rq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_q  = 0;
  int   next_id  = 0;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s item %0d: got %h, expected %h", name, id, act, req);
    end
  endtask

  // Reference model works from field values and register numbers, not bit masks.
  task automatic issue(input logic [31:0] ir, input bit a, input bit b, input bit c,
                       input bit ri, input bit ro, input bit ba);
    exp_t e;
    int   num;
    int   cval;
    @(negedge clk);
    bus.ir_val       = ir;
    bus.Gra          = a;
    bus.Grb          = b;
    bus.Grc          = c;
    bus.r_in_enable  = ri;
    bus.r_out_enable = ro;
    bus.BA_out       = ba;
    num = 0;
    if (a) num = num | int'((ir >> 23) % 16);
    if (b) num = num | int'((ir >> 19) % 16);
    if (c) num = num | int'((ir >> 15) % 16);
    cval = int'(ir % (1 << 19));
    if (cval >= (1 << 18)) cval = cval - (1 << 19);
    if (rst_n && (ri || ro || ba)) model_q = num;
    e.id    = next_id;
    e.rnum  = 4'(num);
    e.sel   = 16'(1 << num);
    e.rin   = ri ? 16'(1 << num) : 16'h0;
    e.rout  = (ro || ba) ? 16'(1 << num) : 16'h0;
    e.cse   = 32'(cval);
    e.multi = (int'(a) + int'(b) + int'(c)) > 1;
    e.rq    = 4'(model_q);
    next_id++;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rnum", e.id, 32'(bus.rnum), 32'(e.rnum));
        check("r_select_vec", e.id, 32'(bus.r_select_vec), 32'(e.sel));
        check("r_in", e.id, 32'(bus.r_in), 32'(e.rin));
        check("r_out", e.id, 32'(bus.r_out), 32'(e.rout));
        check("c_sign_ext", e.id, bus.c_sign_ext, e.cse);
        check("multi_sel", e.id, 32'(bus.multi_sel), 32'(e.multi));
        check("rnum_q", e.id, 32'(bus.rnum_q), 32'(e.rq));
      end
    end
  end

  logic [31:0] ir_567;

  initial begin : driver
    ir_567 = (32'd5 << 23) | (32'd6 << 19) | (32'd7 << 15);
    bus.ir_val       = '0;
    bus.Gra          = 1'b0;
    bus.Grb          = 1'b0;
    bus.Grc          = 1'b0;
    bus.r_in_enable  = 1'b0;
    bus.r_out_enable = 1'b0;
    bus.BA_out       = 1'b0;
    #2;
    check("reset_rnum_q", -1, 32'(bus.rnum_q), 32'd0);

    // Combinational outputs track inputs while reset holds the trace register.
    issue(ir_567, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(ir_567, 1, 0, 0, 1, 0, 0);
    issue(ir_567, 0, 1, 0, 0, 1, 0);
    issue(ir_567, 0, 0, 1, 0, 0, 1);
    issue(ir_567, 0, 0, 0, 1, 1, 0);
    issue(ir_567, 1, 1, 0, 0, 0, 0);
    issue(32'h0004_0000, 0, 0, 0, 0, 0, 0);
    issue(32'h0003_FFFF, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    issue(ir_567, 1, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    model_q = 0;
    #1;
    check("async_reset_rnum_q", -2, 32'(bus.rnum_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(ir_567, 1, 0, 0, 1, 0, 0);
    issue(ir_567, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      issue($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
